mtm_alu_deserializer: RTL and testbench



---
 rtl/mtm_alu_deserializer_if.sv | 12 +
 rtl/mtm_alu_deserializer.sv | 166 ++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_deserializer_if.sv
// Serial-in / parallel-out bundle between the line receiver and the ALU core.
// master: deserializer side (consumes sin, drives operands); slave: core/line side.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  CTL;
  logic        valid;

  modport master (input sin, output A, output B, output CTL, output valid);
  modport slave  (output sin, input A, input B, input CTL, input valid);
endinterface

// File: rtl/mtm_alu_deserializer.sv
// Serial frame receiver for the ALU core: assembles {B,A,cmd}, checks CRC4, strobes valid.
// Optional macro DESER_TIMEOUT_EN aborts a partial transaction after TIMEOUT_CYCLES idle clocks.
module mtm_alu_deserializer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mtm_alu_deserializer_if.master       bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned BIT_W   = 3;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(8);
  localparam logic [CNT_W-1:0]  SAT_CNT  = CNT_W'(9);
  localparam logic [BYTE_W-1:0] ERR_DATA = 8'hC9;
  localparam logic [BYTE_W-1:0] ERR_CRC  = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_e;

  state_e                  state_q,   state_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    is_cmd_q,  is_cmd_d;
  logic [BYTE_W-1:0]       byte_q,    byte_d;
  logic [2*DATA_W-1:0]     shreg_q,   shreg_d;
  logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0]       a_q,       a_d;
  logic [DATA_W-1:0]       b_q,       b_d;
  logic [BYTE_W-1:0]       ctl_q,     ctl_d;
  logic                    valid_q,   valid_d;
  logic                    crc_ok_c;

`ifdef DESER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
`else
  logic                    unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

  // Serial CRC4, x^4+x+1, init 0, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      c = {c[2:0], 1'b0} ^ ({4{c[3] ^ d[i]}} & 4'b0011);
    end
    return c;
  endfunction

  assign crc_ok_c = (crc4({shreg_q, 1'b1, byte_q[6:4]}) == byte_q[3:0]);

  // Frame sequencing, transaction assembly and result selection.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    is_cmd_d  = is_cmd_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    pkt_cnt_d = pkt_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    ctl_d     = ctl_q;
    valid_d   = 1'b0;
`ifdef DESER_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!bus.sin) begin
          state_d = S_TYPE;
`ifdef DESER_TIMEOUT_EN
          idle_cnt_d = '0;
        end else if (pkt_cnt_q != '0 && pkt_cnt_q <= FULL_CNT) begin
          if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt_d = '0;
            pkt_cnt_d  = '0;
            ctl_d      = ERR_DATA;
            valid_d    = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
`endif
        end
      end

      S_TYPE: begin
        is_cmd_d  = bus.sin;
        bit_cnt_d = '0;
        state_d   = S_PAYLOAD;
      end

      S_PAYLOAD: begin
        byte_d    = {byte_q[BYTE_W-2:0], bus.sin};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(7)) state_d = S_STOP;
      end

      S_STOP: begin
        state_d = S_IDLE;
        if (!bus.sin) begin
          pkt_cnt_d = '0;
          ctl_d     = ERR_DATA;
          valid_d   = 1'b1;
        end else if (!is_cmd_q) begin
          shreg_d = {shreg_q[2*DATA_W-BYTE_W-1:0], byte_q};
          if (pkt_cnt_q != SAT_CNT) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else begin
          pkt_cnt_d = '0;
          valid_d   = 1'b1;
          if (pkt_cnt_q != FULL_CNT) begin
            ctl_d = ERR_DATA;
          end else if (crc_ok_c) begin
            b_d   = shreg_q[2*DATA_W-1:DATA_W];
            a_d   = shreg_q[DATA_W-1:0];
            ctl_d = {1'b0, byte_q[BYTE_W-2:0]};
          end else begin
            ctl_d = ERR_CRC;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      is_cmd_q  <= 1'b0;
      byte_q    <= '0;
      shreg_q   <= '0;
      pkt_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= '0;
      valid_q   <= 1'b0;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      is_cmd_q  <= is_cmd_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      pkt_cnt_q <= pkt_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctl_q     <= ctl_d;
      valid_q   <= valid_d;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.CTL   = ctl_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomized self-checking bench for mtm_alu_deserializer against a transaction-level model.
// Honours DESER_TIMEOUT_EN when compiled with it.
module tb_mtm_alu_deserializer;

  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mtm_alu_deserializer_if bus ();

  mtm_alu_deserializer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;

  logic [31:0] exp_a, exp_b;
  logic [7:0]  exp_ctl;
  logic [7:0]  rx_q[$];   // data bytes accepted in the open transaction
  logic [7:0]  txb[$];    // data bytes of the transaction being sent

  always @(posedge clk) if (bus.valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of polynomial long division of stream*x^4 by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [67:0] s);
    logic [71:0] m;
    m = {s, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic void model_reset();
    exp_a = '0; exp_b = '0; exp_ctl = '0;
    rx_q.delete();
  endfunction

  function automatic void model_cmd(input logic [7:0] cmd);
    logic [31:0] a, b;
    exp_pulses++;
    if (rx_q.size() != 8) begin
      exp_ctl = 8'hC9;
    end else begin
      b = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
      a = {rx_q[4], rx_q[5], rx_q[6], rx_q[7]};
      if (ref_crc({b, a, 1'b1, cmd[6:4]}) == cmd[3:0]) begin
        exp_a = a; exp_b = b; exp_ctl = {1'b0, cmd[6:0]};
      end else begin
        exp_ctl = 8'hA5;
      end
    end
    rx_q.delete();
  endfunction

  function automatic logic [7:0] good_cmd(input logic [2:0] op);
    logic [31:0] a, b;
    b = {txb[0], txb[1], txb[2], txb[3]};
    a = {txb[4], txb[5], txb[6], txb[7]};
    return {1'b0, op, ref_crc({b, a, 1'b1, op})};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk) bus.sin = 1'b1;
  endtask

  // Drives one 11-bit frame; returns right after the stop bit is driven.
  task automatic send_frame(input logic is_cmd, input logic [7:0] b, input logic stop);
    logic [10:0] f;
    f = {1'b0, is_cmd, b, stop};
    for (int i = 10; i >= 0; i--) @(negedge clk) bus.sin = f[i];
    if (!stop) begin
      rx_q.delete();
      exp_ctl = 8'hC9;
      exp_pulses++;
    end else if (!is_cmd) begin
      rx_q.push_back(b);
    end else begin
      model_cmd(b);
    end
  endtask

  // Called right after a pulse-producing stop bit.
  task automatic check_result(input string tag);
    @(negedge clk) bus.sin = 1'b1;
    check({tag, "_valid"}, 64'(bus.valid), 64'd1);
    check({tag, "_A"},     64'(bus.A),     64'(exp_a));
    check({tag, "_B"},     64'(bus.B),     64'(exp_b));
    check({tag, "_CTL"},   64'(bus.CTL),   64'(exp_ctl));
    @(negedge clk);
    check({tag, "_valid_off"}, 64'(bus.valid), 64'd0);
    check({tag, "_pulses"},    64'(pulse_cnt), 64'(exp_pulses));
  endtask

  task automatic send_txn(input string tag, input logic [7:0] cmd, input int bad_idx);
    for (int i = 0; i < txb.size(); i++) begin
      send_frame(1'b0, txb[i], i != bad_idx);
      if (i == bad_idx) begin
        check_result(tag);
        return;
      end
      idle($urandom_range(0, 2));
    end
    send_frame(1'b1, cmd, 1'b1);
    check_result(tag);
  endtask

  task automatic load_add();
    txb = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
  endtask

  initial begin
    int n, bad, seen_at;
    logic [7:0] cmd;

    bus.sin = 1'b1;
    rst_n   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_A", 64'(bus.A), 64'd0);
    check("rst_B", 64'(bus.B), 64'd0);
    check("rst_CTL", 64'(bus.CTL), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    idle(2);

    load_add();
    send_txn("add", 8'h4C, -1);
    check("add_ctl_const", 64'(bus.CTL), 64'h4C);
    check("add_A_const", 64'(bus.A), 64'h1);

    load_add();
    send_txn("badcrc", 8'h4D, -1);
    check("badcrc_const", 64'(bus.CTL), 64'hA5);

    txb = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    send_txn("short", 8'h4C, -1);
    check("short_const", 64'(bus.CTL), 64'hC9);
    load_add();
    send_txn("after_short", 8'h4C, -1);

    load_add();
    send_txn("badop", 8'h35, -1);
    check("badop_const", 64'(bus.CTL), 64'h35);

    load_add();
    send_txn("framing", 8'h4C, 2);
    check("framing_const", 64'(bus.CTL), 64'hC9);
    load_add();
    send_txn("after_framing", 8'h4C, -1);

    // Reset in the middle of the 6th data frame.
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'($urandom), 1'b1);
    @(negedge clk) bus.sin = 1'b0;
    @(negedge clk) bus.sin = 1'b0;
    repeat (3) @(negedge clk) bus.sin = 1'($urandom);
    @(negedge clk) begin bus.sin = 1'b1; rst_n = 1'b0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("midrst_A", 64'(bus.A), 64'd0);
    check("midrst_CTL", 64'(bus.CTL), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_pulses", 64'(pulse_cnt), 64'(exp_pulses));
    load_add();
    send_txn("after_rst", 8'h4C, -1);

    // Idle gap inside a partial transaction.
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'($urandom), 1'b1);
`ifdef DESER_TIMEOUT_EN
    seen_at = 0;
    for (int k = 1; k <= int'(TIMEOUT) + 4; k++) begin
      @(negedge clk) bus.sin = 1'b1;
      if (bus.valid === 1'b1 && seen_at == 0) begin
        seen_at = k;
        check("timeout_CTL", 64'(bus.CTL), 64'hC9);
        check("timeout_A", 64'(bus.A), 64'(exp_a));
      end
    end
    check("timeout_seen", 64'(seen_at >= int'(TIMEOUT) && seen_at <= int'(TIMEOUT) + 2), 64'd1);
    rx_q.delete();
    exp_ctl = 8'hC9;
    exp_pulses++;
    check("timeout_pulses", 64'(pulse_cnt), 64'(exp_pulses));
`else
    seen_at = 0;
    idle(3 * int'(TIMEOUT));
    check("no_timeout_pulses", 64'(pulse_cnt), 64'(exp_pulses));
    send_frame(1'b1, 8'h4C, 1'b1);
    check_result("partial_cmd");
`endif

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      n = ($urandom_range(0, 9) < 7) ? 8 : int'($urandom_range(4, 10));
      txb.delete();
      for (int i = 0; i < n; i++) txb.push_back(8'($urandom));
      if (n == 8 && $urandom_range(0, 9) < 6) cmd = good_cmd(3'($urandom));
      else                                     cmd = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      idle($urandom_range(0, 2));
      send_txn("rand", cmd, bad);
    end

    idle(4);
    check("pulse_total", 64'(pulse_cnt), 64'(exp_pulses));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
